// File: rtl/decrypt_pkg.sv
// Shared PRESENT-80 constants, FSM states, S-box tables
// and the bit-permutation index helper.
package decrypt_pkg;

  localparam int size        = 64;
  localparam int key_size    = 80;
  localparam int num_rounds  = 31;
  localparam int rounds_size = 5;

  typedef enum logic [2:0] {
    IDLE,
    KEYGEN,
    ROUNDS,
    FINAL,
    DONE
  } fsm_t;

  localparam logic [3:0] sbox_tab [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] inv_sbox_tab [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // Forward pLayer sends bit i to perm_idx(i)
  function automatic int perm_idx(input int i);
    return (i == 63) ? 63 : (16 * i) % 63;
  endfunction

endpackage

// File: rtl/inv_round.sv
// One PRESENT inverse round, purely combinational:
// key add, inverse permutation, inverse S-box layer.
module inv_round
  import decrypt_pkg::*;
(
  input  logic [size-1:0] state_in,
  input  logic [size-1:0] round_key,
  output logic [size-1:0] state_out
);

  logic [size-1:0] mixed;
  logic [size-1:0] unperm;

  assign mixed = state_in ^ round_key;

  for (genvar i = 0; i < size; i++) begin : g_perm
    localparam int src = perm_idx(i);
    assign unperm[i] = mixed[src];
  end

  for (genvar n = 0; n < size / 4; n++) begin : g_sbox
    assign state_out[4*n+3:4*n] = inv_sbox_tab[unperm[4*n+3:4*n]];
  end

endmodule

// File: rtl/decrypt.sv
// Iterative PRESENT-80 decryptor, one inverse round per cycle.
// Define DECRYPT_KEY_CACHE_EN to reuse K32 when the key repeats.
module decrypt
  import decrypt_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [key_size-1:0] orig_key,
  input  logic [size-1:0]     ciphertext,
  output logic [size-1:0]     plaintext,
  output logic                Busy,
  output logic                Done
);

  localparam logic [rounds_size-1:0] last  = rounds_size'(num_rounds);
  localparam logic [rounds_size-1:0] first = rounds_size'(1);

  fsm_t fsm, fsm_n;

  logic [size-1:0]        state;
  logic [size-1:0]        round_out;
  logic [key_size-1:0]    rk;
  logic [key_size-1:0]    rk_fwd;
  logic [key_size-1:0]    rk_tmp;
  logic [key_size-1:0]    rk_inv;
  logic [key_size-1:0]    cached_k32;
  logic [rounds_size-1:0] ctr;
  logic                   hit;

`ifdef DECRYPT_KEY_CACHE_EN
  logic [key_size-1:0] key_tag;
  logic [key_size-1:0] k32_reg;
  logic                cache_valid;

  assign hit        = cache_valid && (orig_key == key_tag);
  assign cached_k32 = k32_reg;

  // Tag is taken at Start; K32 becomes valid only once KEYGEN ends
  always_ff @(posedge Clock) begin
    if (Reset) begin
      key_tag     <= '0;
      k32_reg     <= '0;
      cache_valid <= 1'b0;
    end else if (fsm == IDLE && Start && !hit) begin
      key_tag     <= orig_key;
      cache_valid <= 1'b0;
    end else if (fsm == KEYGEN && ctr == last) begin
      k32_reg     <= rk_fwd;
      cache_valid <= 1'b1;
    end
  end
`else
  assign hit        = 1'b0;
  assign cached_k32 = '0;
`endif

  always_comb begin
    rk_fwd          = {rk[18:0], rk[79:19]};
    rk_fwd[79:76]   = sbox_tab[rk_fwd[79:76]];
    rk_fwd[19:15]   = rk_fwd[19:15] ^ ctr;
  end

  always_comb begin
    rk_tmp          = rk;
    rk_tmp[19:15]   = rk_tmp[19:15] ^ ctr;
    rk_tmp[79:76]   = inv_sbox_tab[rk_tmp[79:76]];
    rk_inv          = {rk_tmp[60:0], rk_tmp[79:61]};
  end

  inv_round u_inv_round (
    .state_in  (state),
    .round_key (rk[79:16]),
    .state_out (round_out)
  );

  always_ff @(posedge Clock) begin
    if (Reset) fsm <= IDLE;
    else       fsm <= fsm_n;
  end

  always_comb begin
    fsm_n = fsm;
    case (fsm)
      IDLE:    if (Start) fsm_n = hit ? ROUNDS : KEYGEN;
      KEYGEN:  if (ctr == last) fsm_n = ROUNDS;
      ROUNDS:  if (ctr == first) fsm_n = FINAL;
      FINAL:   fsm_n = DONE;
      DONE:    fsm_n = IDLE;
      default: fsm_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= '0;
      rk        <= '0;
      ctr       <= '0;
      plaintext <= '0;
    end else begin
      case (fsm)
        IDLE: if (Start) begin
          state <= ciphertext;
          rk    <= hit ? cached_k32 : orig_key;
          ctr   <= hit ? last : first;
        end
        KEYGEN: begin
          rk <= rk_fwd;
          if (ctr != last) ctr <= ctr + 1'b1;
        end
        ROUNDS: begin
          state <= round_out;
          rk    <= rk_inv;
          ctr   <= ctr - 1'b1;
        end
        FINAL:   plaintext <= state ^ rk[79:16];
        default: ;
      endcase
    end
  end

  assign Busy = (fsm == KEYGEN) || (fsm == ROUNDS) || (fsm == FINAL);
  assign Done = (fsm == DONE);

endmodule

// File: tb/tb_decrypt.sv
// Randomised scoreboard bench for the PRESENT-80 decryptor,
// with a forward-cipher reference model used for round trips.
module tb_decrypt;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [79:0] orig_key;
  logic [63:0] ciphertext;
  logic [63:0] plaintext;
  logic        Busy;
  logic        Done;

  always #5 Clock = ~Clock;

  decrypt dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .orig_key   (orig_key),
    .ciphertext (ciphertext),
    .plaintext  (plaintext),
    .Busy       (Busy),
    .Done       (Done)
  );

  typedef struct {
    logic [63:0] pt;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic [79:0] mc_key;
  bit          mc_valid = 1'b0;

  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Textbook PRESENT-80 encryption
  function automatic logic [63:0] enc(input logic [79:0] key,
                                      input logic [63:0] pt);
    logic [63:0] rks [1:32];
    logic [79:0] k, n;
    logic [63:0] s, t;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      rks[r] = k[79:16];
      for (int j = 0; j < 80; j++) n[(j + 61) % 80] = k[j];
      n[79:76] = SB[n[79:76]];
      n[19:15] = n[19:15] ^ 5'(r);
      k = n;
    end
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ rks[r];
      for (int b = 0; b < 16; b++) s[4*b +: 4] = SB[s[4*b +: 4]];
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (16 * b) % 63] = s[b];
      s = t;
    end
    return s ^ rks[32];
  endfunction

  function automatic int model_lat(input logic [79:0] k);
`ifdef DECRYPT_KEY_CACHE_EN
    return (mc_valid && k == mc_key) ? 33 : 64;
`else
    return 64;
`endif
  endfunction

  always @(posedge Clock) cyc++;

  always @(negedge Clock) begin
    exp_t e;
    if (Done) begin
      done_cnt++;
      checks++;
      if (Busy) begin
        failures++;
        $display("FAIL busy_at_done got=%b want=0", Busy);
      end
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=done want=none");
      end else begin
        e = q.pop_front();
        checks += 2;
        if (plaintext !== e.pt) begin
          failures++;
          $display("FAIL plaintext got=%h want=%h", plaintext, e.pt);
        end
        if (cyc - e.t0 + 1 != e.lat) begin
          failures++;
          $display("FAIL latency got=%0d want=%0d", cyc - e.t0 + 1, e.lat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic do_txn(input logic [79:0] k, input logic [63:0] ct,
                        input logic [63:0] pt, input int glitch);
    int lat, d0, n;
    exp_t e;
    lat = model_lat(k);
    @(negedge Clock);
    orig_key   = k;
    ciphertext = ct;
    Start      = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    e.pt = pt;
    e.lat = lat;
    e.t0 = cyc;
    q.push_back(e);
    chk("busy_start", 64'(Busy), 64'd1);
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge Clock);
      n++;
      if (glitch != 0 && n == glitch) begin
        Start      = 1'b1;
        orig_key   = ~k;
        ciphertext = ~ct;
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    checks++;
    if (done_cnt == d0) begin
      failures++;
      $display("FAIL done_timeout got=none want=done");
      q.delete();
    end
    @(negedge Clock);
    mc_key   = k;
    mc_valid = 1'b1;
  endtask

  initial begin
    logic [79:0] k;
    logic [63:0] pt;
    int d;
    Reset      = 1'b1;
    Start      = 1'b0;
    orig_key   = '0;
    ciphertext = '0;
    repeat (3) @(negedge Clock);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_pt", plaintext, 64'd0);
    Reset = 1'b0;

    do_txn(80'h0, 64'h5579C1387B228445, 64'h0, 0);
    do_txn({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0, 0);
    do_txn(80'h0, 64'hA112FFC72F68417B, {64{1'b1}}, 0);
    do_txn({80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}}, 0);

    k  = {$urandom(), $urandom(), $urandom()};
    pt = {$urandom(), $urandom()};
    d  = done_cnt;
    do_txn(k, enc(k, pt), pt, 40);
    repeat (100) @(negedge Clock);
    chk("single_done", 64'(done_cnt - d), 64'd1);

    k  = {$urandom(), $urandom(), $urandom()};
    pt = {$urandom(), $urandom()};
    do_txn(k, enc(k, pt), pt, 0);
    pt = {$urandom(), $urandom()};
    do_txn(k, enc(k, pt), pt, 0);
    k  = ~k;
    pt = {$urandom(), $urandom()} | 64'h1;
    do_txn(k, enc(k, pt), pt, 0);

    k = {$urandom(), $urandom(), $urandom()};
    @(negedge Clock);
    orig_key   = k;
    ciphertext = {$urandom(), $urandom()};
    Start      = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (38) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_done", 64'(Done), 64'd0);
    chk("midrst_pt", plaintext, 64'd0);
    Reset    = 1'b0;
    mc_valid = 1'b0;
    pt = {$urandom(), $urandom()};
    do_txn(k, enc(k, pt), pt, 0);

    for (int i = 0; i < 1000; i++) begin
      k  = {$urandom(), $urandom(), $urandom()};
      pt = {$urandom(), $urandom()};
      do_txn(k, enc(k, pt), pt, 0);
    end

    repeat (5) @(negedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
